traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Safety monitor on the receive side of the four-way lamp interface: samples the north/south/east/west lamp buses driven by the traffic controller and decodes them back into a phase index. It checks every sample against the legal phase sequence and the green/yellow dwell times, and latches the first violation as a sticky fault with a code. It sits beside the controller and feeds the fault-handling/flash-red logic and the status registers.

## Interface

- GREEN_CYC, 8, required samples per green phase (1..255)
- YELLOW_CYC, 4, required samples per yellow phase (1..255)

- clk  input  1  sampling clock, same clock as the controller
- rst_a  input  1  synchronous, active-high reset
- n_lights  input  3  north lamps: 3'b001 green, 3'b010 yellow, 3'b100 red
- s_lights  input  3  south lamps, same encoding
- e_lights  input  3  east lamps, same encoding
- w_lights  input  3  west lamps, same encoding
- phase  output  3  decoded current phase: 0 N, 1 N-yellow, 2 S, 3 S-yellow, 4 E, 5 E-yellow, 6 W, 7 W-yellow
- phase_valid  output  1  high while tracking with no fault
- fault  output  1  sticky, first violation since reset
- fault_code  output  3  code of first violation, 0 when no fault
- cycle_count  output  8  completed rotations (W-yellow to N transitions), wraps 255 to 0

## Operation

- Input stage: all four buses registered every clk into a sample register; all checks run on the registered sample.
- Checks on each sample, in priority order (lowest code wins when several fire together):
  - 1 encoding: any bus not in {001, 010, 100}
  - 2 conflict: more than one bus non-red
  - 3 all-red: all four buses red
  - 4 sequence: phase differs from the previous one and is not previous+1 mod 8
  - 5 long dwell: same phase as previous while the dwell count already equals its limit
  - 6 short dwell: phase change while the dwell count of the finished phase is below its limit
- Dwell limit: GREEN_CYC for even phases, YELLOW_CYC for odd phases. The dwell counter is 8 bits and holds the number of samples of the current phase.
- State machine:
  - UNSYNC (reset state): first sample with no code 1-3 violation loads phase, sets dwell=1, and moves to TRACK. That first phase is exempt from the code 6 check only; it is still subject to code 5. Samples with a code 1-3 violation go to FAULT.
  - TRACK, same phase: dwell+1.
  - TRACK, legal successor phase: phase updates, dwell=1. A W-yellow to N transition increments cycle_count.
  - TRACK, any violation: go to FAULT. fault=1, fault_code=code. phase holds its last legal value and dwell freezes.
  - FAULT: absorbing. Outputs hold and inputs are ignored until rst_a.
- phase_valid = (state == TRACK).

## Timing

- Reset (rst_a high at a clk edge): phase=0, phase_valid=0, fault=0, fault_code=0, cycle_count=0, state UNSYNC, sample register cleared to all-red. The cleared sample is not checked.
- Reset has priority over every other event, including a violation in the same cycle. Asserting reset mid-fault or mid-phase clears everything at that edge.
- Latency: lamp value present at edge k is sampled at edge k. phase, phase_valid, fault and fault_code reflect it after edge k+1.
- Synchronous start: if monitor and controller leave reset on the same edge, phase_valid rises one cycle after the first sample. A legal stream then never faults: N lasts 8 samples, each yellow 4.
- Dwell boundaries with GREEN_CYC=8:
  - 8th sample of N: legal.
  - 9th sample of N: code 5.
  - change to N-yellow after 7 N samples: code 6.
- Only the first violation is recorded; later violations never overwrite fault_code.

## Test plan

- Reset both blocks together, drive 2 legal rotations (8/4 dwells) -> fault=0 throughout, phase steps 0..7 twice, cycle_count=2, phase_valid=1 from the cycle after the first sample.
- During N green, drive n=001 and e=001 for one cycle -> fault=1, fault_code=2 two edges later, phase=0 held, phase_valid=0.
- Drive n_lights=3'b011 with the other buses red -> fault_code=1. In a separate run, drive all four buses 3'b100 in TRACK -> fault_code=3.
- After 8 N-green samples, jump straight to S green -> fault_code=4. Same violation with n_lights also set to 3'b110 -> fault_code=1 (priority).
- Hold N green for 9 samples -> fault_code=5. In a separate run, hold S-yellow for 3 samples then E green -> fault_code=6.
- Start the monitor mid-E-green with 3 samples left -> no fault, syncs to phase 4, cycle_count increments at the next N. Then force a fault and pulse rst_a -> all outputs 0 after that edge, then re-sync.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//
// Receive-side safety monitor for the four-way lamp interface. The N/S/E/W
// lamp buses are registered every clk, decoded back into a phase index and
// checked against the legal phase rotation and the green/yellow dwell times.
// The first violation is latched as a sticky fault with a code.
//
// Parameters
//   GREEN_CYC   required samples per green phase  (1..255)
//   YELLOW_CYC  required samples per yellow phase (1..255)
//
// Ports
//   clk          sampling clock (same clock as the controller)
//   rst_a        synchronous active-high reset
//   n/s/e/w_lights  lamp buses: 001 green, 010 yellow, 100 red
//   phase        decoded phase: 0 N, 1 N-Y, 2 S, 3 S-Y, 4 E, 5 E-Y, 6 W, 7 W-Y
//   phase_valid  high while tracking with no fault
//   fault        sticky, first violation since reset
//   fault_code   code of the first violation, 0 when no fault
//   cycle_count  completed rotations (W-yellow -> N), wraps
// ---------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_count
);

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_RED = 3'b100;

    // Sample register, bus index 0 N, 1 S, 2 E, 3 W.
    logic [3:0][2:0] samp;
    // Low for the first edge after reset so the cleared all-red sample is
    // never checked.
    logic            samp_vld;

    logic [1:0] state;
    logic [7:0] dwell;
    logic       first_ph;   // still in the phase we synced on: no short-dwell check

    always_ff @(posedge clk) begin
        if (rst_a) begin
            samp     <= {4{LAMP_RED}};
            samp_vld <= 1'b0;
        end else begin
            samp     <= {w_lights, e_lights, s_lights, n_lights};
            samp_vld <= 1'b1;
        end
    end

    // ---------------- decode ----------------
    logic [3:0] bad_enc;
    logic [3:0] non_red;
    logic [2:0] dec_phase;

    always_comb begin
        bad_enc   = '0;
        non_red   = '0;
        dec_phase = 3'd0;
        for (int i = 0; i < 4; i++) begin
            bad_enc[i] = !(samp[i] == LAMP_GRN || samp[i] == LAMP_YEL ||
                           samp[i] == LAMP_RED);
            non_red[i] = (samp[i] != LAMP_RED);
            if (non_red[i])
                dec_phase = {2'(i), samp[i] == LAMP_YEL};
        end
    end

    logic       enc_err, conflict, all_red;
    logic [7:0] dwell_lim;
    logic [2:0] succ_phase;

    assign enc_err    = |bad_enc;
    assign conflict   = (non_red & (non_red - 4'd1)) != 4'd0;  // >1 bit set
    assign all_red    = (non_red == 4'd0);
    assign dwell_lim  = phase[0] ? 8'(YELLOW_CYC) : 8'(GREEN_CYC);
    assign succ_phase = phase + 3'd1;

    // ---------------- violation code, lowest wins ----------------
    logic [2:0] code;

    always_comb begin
        code = 3'd0;
        if (enc_err)
            code = 3'd1;
        else if (conflict)
            code = 3'd2;
        else if (all_red)
            code = 3'd3;
        else if (state == ST_TRACK) begin
            if (dec_phase != phase && dec_phase != succ_phase)
                code = 3'd4;
            else if (dec_phase == phase && dwell == dwell_lim)
                code = 3'd5;
            else if (dec_phase != phase && dwell < dwell_lim && !first_ph)
                code = 3'd6;
        end
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state       <= ST_UNSYNC;
            phase       <= 3'd0;
            dwell       <= 8'd0;
            first_ph    <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            cycle_count <= 8'd0;
        end else if (samp_vld) begin
            case (state)
                ST_UNSYNC: begin
                    if (code != 3'd0) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= code;
                    end else begin
                        state    <= ST_TRACK;
                        phase    <= dec_phase;
                        dwell    <= 8'd1;
                        first_ph <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (code != 3'd0) begin
                        // phase and dwell freeze at their last legal values
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= code;
                    end else if (dec_phase == phase) begin
                        dwell <= dwell + 8'd1;
                    end else begin
                        phase    <= dec_phase;
                        dwell    <= 8'd1;
                        first_ph <= 1'b0;
                        if (phase == 3'd7)
                            cycle_count <= cycle_count + 8'd1;
                    end
                end
                ST_FAULT: ;  // absorbing until reset
                default: state <= ST_FAULT;
            endcase
        end
    end

    assign phase_valid = (state == ST_TRACK);

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    localparam int GREEN_CYC  = 8;
    localparam int YELLOW_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic [2:0] n_lights = 3'b100, s_lights = 3'b100, e_lights = 3'b100, w_lights = 3'b100;
    logic [2:0] phase;
    logic       phase_valid, fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_count;

    traffic_light_monitor #(.GREEN_CYC(GREEN_CYC), .YELLOW_CYC(YELLOW_CYC)) dut (
        .clk(clk), .rst_a(rst_a),
        .n_lights(n_lights), .s_lights(s_lights), .e_lights(e_lights), .w_lights(w_lights),
        .phase(phase), .phase_valid(phase_valid), .fault(fault),
        .fault_code(fault_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        int due;   // posedge count after which these outputs must be visible
        int ph;
        bit vld;
        bit flt;
        int code;
        int rot;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_no = 0;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // Tracks the spec rules directly: a "synced" flag, the current phase, how
    // many samples it has lasted, and how many rotations have completed.
    bit m_sync, m_flt, m_first;
    int m_ph, m_dwell, m_code, m_rot;

    function automatic int lim_of(int p);
        return (p % 2 == 1) ? YELLOW_CYC : GREEN_CYC;
    endfunction

    function automatic logic [2:0] lamp_of(int p, int bus);
        if (bus != p / 2) return 3'b100;
        return (p % 2 == 1) ? 3'b010 : 3'b001;
    endfunction

    function void model_reset();
        m_sync = 0; m_flt = 0; m_first = 0;
        m_ph = 0; m_dwell = 0; m_code = 0; m_rot = 0;
    endfunction

    function void model_step(logic [2:0] n, logic [2:0] s, logic [2:0] e, logic [2:0] w);
        logic [2:0] b[4];
        int code, lit, dec;
        bit bad;
        b[0] = n; b[1] = s; b[2] = e; b[3] = w;
        code = 0; lit = 0; dec = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (b[i] != 3'b001 && b[i] != 3'b010 && b[i] != 3'b100) bad = 1;
            if (b[i] != 3'b100) begin
                lit++;
                dec = 2 * i + ((b[i] == 3'b010) ? 1 : 0);
            end
        end
        if (bad) code = 1;
        else if (lit > 1) code = 2;
        else if (lit == 0) code = 3;

        if (m_flt) return;
        if (!m_sync) begin
            if (code != 0) begin
                m_flt = 1; m_code = code;
            end else begin
                m_sync = 1; m_ph = dec; m_dwell = 1; m_first = 1;
            end
            return;
        end
        if (code == 0) begin
            if (dec != m_ph && dec != (m_ph + 1) % 8) code = 4;
            else if (dec == m_ph && m_dwell >= lim_of(m_ph)) code = 5;
            else if (dec != m_ph && m_dwell < lim_of(m_ph) && !m_first) code = 6;
        end
        if (code != 0) begin
            m_flt = 1; m_code = code;
        end else if (dec == m_ph) begin
            m_dwell++;
        end else begin
            if (m_ph == 7) m_rot = (m_rot + 1) % 256;
            m_ph = dec; m_dwell = 1; m_first = 0;
        end
    endfunction

    function void push(int due);
        exp_t x;
        x.due = due; x.ph = m_ph; x.vld = m_sync && !m_flt;
        x.flt = m_flt; x.code = m_code; x.rot = m_rot;
        sb.push_back(x);
    endfunction

    // ---------------- stimulus tasks ----------------
    // Inputs driven at the negedge after edge j are sampled at edge j+1 and
    // show on the outputs after edge j+2.
    task automatic drive(input logic [2:0] n, input logic [2:0] s,
                         input logic [2:0] e, input logic [2:0] w);
        @(negedge clk);
        rst_a = 1'b0;
        n_lights = n; s_lights = s; e_lights = e; w_lights = w;
        model_step(n, s, e, w);
        push(edge_no + 2);
    endtask

    task automatic drive_phase(input int p, input int cnt);
        repeat (cnt) drive(lamp_of(p, 0), lamp_of(p, 1), lamp_of(p, 2), lamp_of(p, 3));
    endtask

    // Reset at edge j+1: any expectation due then is superseded. The edge
    // after reset still shows reset values because the cleared sample is
    // not checked.
    task automatic do_reset();
        @(negedge clk);
        rst_a = 1'b1;
        while (sb.size() > 0 && sb[$].due >= edge_no + 1) void'(sb.pop_back());
        model_reset();
        push(edge_no + 1);
        push(edge_no + 2);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        edge_no++;
        while (sb.size() > 0 && sb[0].due < edge_no) begin
            mon_e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missed_check due=%0d now=%0d", mon_e.due, edge_no);
        end
        if (sb.size() > 0 && sb[0].due == edge_no) begin
            mon_e = sb.pop_front();
            checks++;
            if (int'(phase) != mon_e.ph || phase_valid !== mon_e.vld || fault !== mon_e.flt ||
                int'(fault_code) != mon_e.code || int'(cycle_count) != mon_e.rot ||
                $isunknown({phase, phase_valid, fault, fault_code, cycle_count})) begin
                errors++;
                $display("FAIL outputs edge=%0d got ph=%0d vld=%0b flt=%0b code=%0d cnt=%0d exp ph=%0d vld=%0b flt=%0b code=%0d cnt=%0d",
                         edge_no, phase, phase_valid, fault, fault_code, cycle_count,
                         mon_e.ph, mon_e.vld, mon_e.flt, mon_e.code, mon_e.rot);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [2:0] rb[4];
    initial begin
        model_reset();
        @(negedge clk);

        // Legal stream, two full rotations from a synchronous start.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 8; p++) drive_phase(p, lim_of(p));
        drive_phase(0, 3);

        // Conflict during N green, then more garbage must not overwrite code 2.
        do_reset();
        drive_phase(0, 3);
        drive(3'b001, 3'b100, 3'b001, 3'b100);
        drive(3'b011, 3'b100, 3'b100, 3'b100);
        drive(3'b100, 3'b100, 3'b100, 3'b100);
        drive_phase(0, 2);

        // Bad encoding, and all-red in TRACK.
        do_reset();
        drive_phase(0, 2);
        drive(3'b011, 3'b100, 3'b100, 3'b100);
        drive_phase(0, 2);
        do_reset();
        drive_phase(0, 2);
        drive(3'b100, 3'b100, 3'b100, 3'b100);
        drive_phase(0, 2);

        // Sequence skip, and the same skip masked by a bad encoding.
        do_reset();
        drive_phase(0, 8);
        drive_phase(2, 3);
        do_reset();
        drive_phase(0, 8);
        drive(3'b110, 3'b001, 3'b100, 3'b100);
        drive_phase(2, 2);

        // Long dwell (9th N sample) and short dwell (S-yellow only 3).
        do_reset();
        drive_phase(0, 9);
        drive_phase(1, 2);
        do_reset();
        drive_phase(0, 8); drive_phase(1, 4); drive_phase(2, 8); drive_phase(3, 3);
        drive_phase(4, 3);

        // Dwell boundary: change to N-yellow after 7 N samples (after a
        // full first phase so the sync exemption no longer applies).
        do_reset();
        for (int p = 0; p < 8; p++) drive_phase(p, lim_of(p));
        drive_phase(0, 7);
        drive_phase(1, 2);

        // Mid-E-green start, rotation into N, fault, reset, re-sync.
        do_reset();
        drive_phase(4, 3); drive_phase(5, 4); drive_phase(6, 8); drive_phase(7, 4);
        drive_phase(0, 3);
        drive(3'b001, 3'b001, 3'b100, 3'b100);
        drive_phase(0, 2);
        do_reset();
        drive_phase(0, 8); drive_phase(1, 2);

        // Randomized streams: mostly legal with occasional disturbances.
        for (int run = 0; run < 30; run++) begin
            int p, r, ev;
            do_reset();
            p = $urandom_range(0, 7);
            r = $urandom_range(1, lim_of(p));
            for (int k = 0; k < 60; k++) begin
                ev = $urandom_range(0, 119);
                if (ev == 0) begin
                    for (int i = 0; i < 4; i++) begin
                        case ($urandom_range(0, 3))
                            0: rb[i] = 3'b001;
                            1: rb[i] = 3'b010;
                            2: rb[i] = 3'b100;
                            default: rb[i] = 3'($urandom);
                        endcase
                    end
                    drive(rb[0], rb[1], rb[2], rb[3]);
                end else if (ev == 1) begin
                    r = 1;                        // cut current phase short
                end else if (ev == 2) begin
                    r++;                          // overstay by one
                end else if (ev == 3) begin
                    p = (p + 2) % 8; r = lim_of(p);  // skip a phase
                end else if (ev == 4) begin
                    do_reset();
                end else begin
                    drive_phase(p, 1);
                    r--;
                    if (r == 0) begin
                        p = (p + 1) % 8;
                        r = lim_of(p);
                    end
                end
            end
        end

        // Drain: let every queued expectation come due.
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
